bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 9 +
 rtl/bus_arbiter_rr_pick.sv | 23 ++
 rtl/bus_arbiter.sv | 76 +++++++
 tb/tb_bus_arbiter.sv | 123 ++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared state encodings, default sizes and index-width helper for bus_arbiter
package bus_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, TURN = 2'd2} state_t;
  localparam int DEF_N_REQ = 4;
  localparam int DEF_MAX_BURST = 8;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner search starting just after last_owner
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [W-1:0]     last_owner,
  output logic [W-1:0]     win_idx,
  output logic             any_req
);
  int j;
  // scan offsets from farthest to nearest so the nearest set bit after last_owner wins
  always_comb begin
    j = 0;
    win_idx = last_owner;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = int'(last_owner) + 1 + i;
      j = j >= N_REQ ? j - N_REQ : j;
      win_idx = req[W'(j)] ? W'(j) : win_idx;
    end
  end
  assign any_req = |req;
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin tristate bus arbiter with a one-cycle turnaround; BUS_ARB_BURST_LIMIT_EN caps grants at MAX_BURST cycles
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          oe,
  output logic [idx_w(N_REQ)-1:0]   owner,
  output logic                      busy
);
  localparam int W = idx_w(N_REQ);
  state_t state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [W-1:0] owner_q, owner_d, last_q, last_d, win_idx;
  logic any_req, rel;
  rr_pick #(.N_REQ(N_REQ), .W(W)) u_pick (
    .req(req),
    .last_owner(last_q),
    .win_idx(win_idx),
    .any_req(any_req)
  );
`ifdef BUS_ARB_BURST_LIMIT_EN
  localparam int CW = idx_w(MAX_BURST + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign rel = !req[owner_q] || cnt_q == CW'(MAX_BURST - 1);
  assign cnt_d = (state_q == GRANT && state_d == GRANT) ? cnt_q + CW'(1) : '0;
  // burst length counter, cleared whenever the bus is not held
  always_ff @(posedge clk)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  assign rel = !req[owner_q];
`endif
  // next-state: hold grant until release, otherwise arbitrate from IDLE or TURN
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    owner_d = owner_q;
    last_d = last_q;
    if (state_q == GRANT) begin
      if (rel) begin
        state_d = TURN;
        gnt_d = '0;
        last_d = owner_q;
      end
    end else if (any_req) begin
      state_d = GRANT;
      gnt_d = N_REQ'(1) << win_idx;
      owner_d = win_idx;
    end else begin
      state_d = IDLE;
    end
  end
  // state, grant and owner registers
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      gnt_q <= '0;
      owner_q <= '0;
      last_q <= W'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      owner_q <= owner_d;
      last_q <= last_d;
    end
  assign gnt = gnt_q;
  assign oe = gnt_q;
  assign owner = owner_q;
  assign busy = |gnt_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scoreboard bench for bus_arbiter, burst-limit aware via BUS_ARB_BURST_LIMIT_EN
module tb_bus_arbiter;
  typedef struct {
    logic [3:0] g;
    logic [1:0] o;
    string nm;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] gnt, oe;
  logic [1:0] owner;
  logic busy;
  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  bus_arbiter #(.N_REQ(4), .MAX_BURST(8)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .gnt(gnt),
    .oe(oe),
    .owner(owner),
    .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask
  task automatic step(input logic r, input logic [3:0] q, input logic [3:0] g, input logic [1:0] o, input string nm);
    exp_t e;
    @(negedge clk);
    reset = r;
    req = q;
    e.g = g;
    e.o = o;
    e.nm = nm;
    sb.push_back(e);
    @(posedge clk);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({e.nm, ".gnt"}, 32'(gnt), 32'(e.g));
        chk({e.nm, ".owner"}, 32'(owner), 32'(e.o));
        chk({e.nm, ".busy"}, 32'(busy), 32'(|e.g));
        chk("onehot0", 32'($onehot0(gnt)), 32'd1);
        chk("oe_eq_gnt", 32'(oe), 32'(gnt));
        chk("busy_eq_or", 32'(busy), 32'(|gnt));
      end
    end
  end
  initial begin
    step(1, 4'b0000, 4'b0000, 0, "reset");
    step(1, 4'b1111, 4'b0000, 0, "reset_ignores_req");
    step(0, 4'b0001, 4'b0001, 0, "single_grant");
    repeat (3) step(0, 4'b0001, 4'b0001, 0, "single_hold");
    step(0, 4'b0000, 4'b0000, 0, "single_release");
    step(0, 4'b0000, 4'b0000, 0, "single_idle");
    step(1, 4'b0000, 4'b0000, 0, "rr_reset");
    step(0, 4'b1111, 4'b0001, 0, "rr_g0");
    step(0, 4'b1111, 4'b0001, 0, "rr_h0");
    step(0, 4'b1110, 4'b0000, 0, "rr_t0");
    step(0, 4'b1111, 4'b0010, 1, "rr_g1");
    step(0, 4'b1111, 4'b0010, 1, "rr_h1");
    step(0, 4'b1101, 4'b0000, 1, "rr_t1");
    step(0, 4'b1111, 4'b0100, 2, "rr_g2");
    step(0, 4'b1111, 4'b0100, 2, "rr_h2");
    step(0, 4'b1011, 4'b0000, 2, "rr_t2");
    step(0, 4'b1111, 4'b1000, 3, "rr_g3");
    step(0, 4'b1111, 4'b1000, 3, "rr_h3");
    step(0, 4'b0111, 4'b0000, 3, "rr_t3");
    step(0, 4'b1111, 4'b0001, 0, "rr_wrap0");
    step(0, 4'b0000, 4'b0000, 0, "rr_end_t");
    step(0, 4'b0000, 4'b0000, 0, "rr_end_idle");
    step(0, 4'b0100, 4'b0100, 2, "pulse_g2");
    step(0, 4'b0101, 4'b0100, 2, "pulse_req0");
    step(0, 4'b0100, 4'b0100, 2, "pulse_after");
    step(0, 4'b0100, 4'b0100, 2, "pulse_hold");
    step(0, 4'b0000, 4'b0000, 2, "pulse_release");
    step(0, 4'b0000, 4'b0000, 2, "pulse_idle");
    step(0, 4'b0010, 4'b0010, 1, "regrant_g1");
    step(0, 4'b0000, 4'b0000, 1, "regrant_turn");
    step(0, 4'b0010, 4'b0010, 1, "regrant_again");
    step(0, 4'b0000, 4'b0000, 1, "regrant_release");
    step(0, 4'b0000, 4'b0000, 1, "regrant_idle");
    step(1, 4'b0000, 4'b0000, 0, "burst_reset");
`ifdef BUS_ARB_BURST_LIMIT_EN
    repeat (8) step(0, 4'b0011, 4'b0001, 0, "burst_own0");
    step(0, 4'b0011, 4'b0000, 0, "burst_turn0");
    repeat (8) step(0, 4'b0011, 4'b0010, 1, "burst_own1");
    step(0, 4'b0011, 4'b0000, 1, "burst_turn1");
    step(0, 4'b0011, 4'b0001, 0, "burst_back0");
`else
    repeat (50) step(0, 4'b0011, 4'b0001, 0, "unbounded_own0");
`endif
    step(0, 4'b0000, 4'b0000, 0, "burst_release");
    step(0, 4'b0000, 4'b0000, 0, "burst_idle");
    step(0, 4'b1000, 4'b1000, 3, "rst_g3");
    step(0, 4'b1000, 4'b1000, 3, "rst_h3");
    step(1, 4'b1000, 4'b0000, 0, "rst_mid_grant");
    step(0, 4'b1000, 4'b1000, 3, "rst_regrant3");
    step(1, 4'b1001, 4'b0000, 0, "rst_again");
    step(0, 4'b1001, 4'b0001, 0, "rst_grant0");
    step(0, 4'b0000, 4'b0000, 0, "rst_release");
    step(0, 4'b0000, 4'b0000, 0, "rst_idle");
    repeat (5) begin
      if (sb.size() != 0) @(posedge clk);
    end
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
